// File: rtl/rcomp_frame_pkg.sv
// rcomp_frame_pkg
// Shared definitions for the frame-level receive controller: parser state
// encoding, the error cause codes reported on err_code, the default frame
// start byte, and a helper that sizes buffer addresses.
package rcomp_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_CMD,
    ST_DATA,
    ST_SUM,
    ST_DRAIN
  } frame_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_SUM  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  // A depth of 1 would otherwise give a zero-width address.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rcomp_frame_buf.sv
// rcomp_frame_buf
// Payload buffer for one frame: MAX_LEN x 8-bit register array with a
// synchronous write port and an asynchronous (combinational) read port.
// Ports:
//   clk     - system clock
//   wr_en   - write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr - write address
//   wr_data - byte to store
//   rd_addr - read address
//   rd_data - byte at rd_addr, combinational
// Contents are not reset; the controller never reads a location before it
// has been written within the same frame.
module rcomp_frame_buf
  import rcomp_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned AW      = addr_width(MAX_LEN)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/rcomp_frame_ctrl.sv
// rcomp_frame_ctrl
// Frame-level receive controller behind the byte UART receiver. Parses
// HDR / LEN / CMD / payload / SUM frames, buffers the payload, verifies the
// 8-bit additive checksum (LEN + CMD + payload) and releases only verified
// frames as a valid/ready byte stream. Supervises the link with an
// inter-byte timeout and counts bytes discarded while draining.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   byte_done, byte_data  - one-cycle received-byte strobe and its data
//   frm_cmd, frm_len      - command and payload length of the frame draining
//   out_data, out_valid   - payload byte stream (valid/ready)
//   out_ready             - consumer accept
//   out_last              - final payload byte, qualified by out_valid
//   err, err_code         - one-cycle error pulse and its held cause
//   drop_cnt              - saturating count of bytes lost during drain
module rcomp_frame_ctrl
  import rcomp_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_done,
  input  logic [7:0] byte_data,
  output logic [7:0] frm_cmd,
  output logic [7:0] frm_len,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] drop_cnt
);

  localparam int unsigned AW        = addr_width(MAX_LEN);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);

  frame_state_e state_q, state_d;
  logic [7:0]   frm_cmd_q, frm_cmd_d;
  logic [7:0]   frm_len_q, frm_len_d;
  logic [7:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]   sum_q, sum_d;
  logic [31:0]  tmo_q, tmo_d;
  logic         out_valid_q, out_valid_d;
  logic         err_q, err_d;
  logic [1:0]   err_code_q, err_code_d;
  logic [7:0]   drop_cnt_q, drop_cnt_d;

  logic         buf_we;
  logic         handshake;
  logic         last_rd;
  logic [7:0]   buf_rd_data;

  rcomp_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (byte_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (buf_rd_data)
  );

  assign handshake = out_valid_q && out_ready;
  assign last_rd   = (rd_ptr_q == frm_len_q - 8'd1);

  // Parser next-state, checksum, pointers, timeout and drop counting.
  always_comb begin
    state_d    = state_q;
    frm_cmd_d  = frm_cmd_q;
    frm_len_d  = frm_len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sum_d      = sum_q;
    tmo_d      = tmo_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    drop_cnt_d = drop_cnt_q;
    buf_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_done && byte_data == HDR_BYTE) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (byte_done) begin
          frm_len_d = byte_data;
          if (byte_data == 8'd0 || byte_data > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (byte_done) begin
          frm_cmd_d = byte_data;
          sum_d     = frm_len_q + byte_data;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_done) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 8'd1;
          sum_d    = sum_q + byte_data;
          if (wr_ptr_q == frm_len_q - 8'd1) begin
            state_d = ST_SUM;
          end
        end
      end
      ST_SUM: begin
        if (byte_done) begin
          if (byte_data == sum_q) begin
            state_d = ST_DRAIN;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_SUM;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          rd_ptr_d = rd_ptr_q + 8'd1;
          if (last_rd) begin
            state_d = ST_IDLE;
          end
        end
        // The UART cannot be stalled, so a byte arriving now is simply lost.
        if (byte_done && drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Inter-byte timeout while a frame is being received; a byte landing
    // on the terminal count wins and restarts the count.
    if (state_q == ST_LEN || state_q == ST_CMD ||
        state_q == ST_DATA || state_q == ST_SUM) begin
      if (byte_done) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d      = '0;
        err_d      = 1'b1;
        err_code_d = ERR_TMO;
        state_d    = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end

    if (state_d == ST_IDLE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      sum_d    = '0;
      tmo_d    = '0;
    end else if (state_d == ST_DRAIN) begin
      tmo_d = '0;
    end

    out_valid_d = (state_d == ST_DRAIN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frm_cmd_q   <= '0;
      frm_len_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      frm_cmd_q   <= frm_cmd_d;
      frm_len_q   <= frm_len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frm_cmd   = frm_cmd_q;
  assign frm_len   = frm_len_q;
  assign out_valid = out_valid_q;
  assign out_data  = buf_rd_data;
  assign out_last  = (state_q == ST_DRAIN) && last_rd;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rcomp_frame_ctrl.sv
// tb_rcomp_frame_ctrl
// Scoreboard bench for rcomp_frame_ctrl: expected payload bytes and error
// codes are queued as frames are driven and compared as the DUT emits them.
module tb_rcomp_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_done = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic [7:0] frm_cmd;
  logic [7:0] frm_len;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] cmd;
    logic [7:0] len;
    logic       last;
  } exp_t;

  exp_t       expQ[$];
  logic [1:0] errQ[$];
  logic [7:0] pay[$];
  bit         toggleMode = 1'b0;

  rcomp_frame_ctrl #(
    .MAX_LEN     (16),
    .TIMEOUT_CYC (20),
    .HDR_BYTE    (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_done (byte_done),
    .byte_data (byte_data),
    .frm_cmd   (frm_cmd),
    .frm_len   (frm_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .err       (err),
    .err_code  (err_code),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // All input tasks enter and leave just after a rising edge.
  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    byte_done = 1'b1;
    byte_data = b;
    @(posedge clk);
    #1;
    byte_done = 1'b0;
  endtask

  function automatic logic [7:0] frameSum(input logic [7:0] cmd);
    logic [7:0] s;
    s = 8'(pay.size()) + cmd;
    foreach (pay[i]) s = s + pay[i];
    return s;
  endfunction

  task automatic pushFrame(input logic [7:0] cmd);
    exp_t e;
    foreach (pay[i]) begin
      e.data = pay[i];
      e.cmd  = cmd;
      e.len  = 8'(pay.size());
      e.last = (i == pay.size() - 1);
      expQ.push_back(e);
    end
  endtask

  // Sends a complete, correctly summed frame built from pay.
  task automatic sendGood(input logic [7:0] cmd);
    applyStimulus(8'hA5);
    applyStimulus(8'(pay.size()));
    applyStimulus(cmd);
    foreach (pay[i]) applyStimulus(pay[i]);
    pushFrame(cmd);
    applyStimulus(frameSum(cmd));
    checkOutput("valid_latency", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_done", expQ.size(), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    checkOutput({tag, "_frm_cmd"}, {24'd0, frm_cmd}, 32'd0);
    checkOutput({tag, "_frm_len"}, {24'd0, frm_len}, 32'd0);
    checkOutput({tag, "_drop_cnt"}, {24'd0, drop_cnt}, 32'd0);
    checkOutput({tag, "_last"}, {31'd0, out_last}, 32'd0);
  endtask

  // Consumer: ready held high, or toggled every cycle for backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggleMode ? ~out_ready : 1'b1;
    end
  end

  // Output monitor: compares the head of the scoreboard every valid cycle,
  // so a stalled byte must match the same entry until it is accepted.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        checkOutput("out_data", {24'd0, out_data}, {24'd0, expQ[0].data});
        checkOutput("frm_cmd", {24'd0, frm_cmd}, {24'd0, expQ[0].cmd});
        checkOutput("frm_len", {24'd0, frm_len}, {24'd0, expQ[0].len});
        checkOutput("out_last", {31'd0, out_last}, {31'd0, expQ[0].last});
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  // Error monitor: every err pulse must match a queued expected code.
  always @(negedge clk) begin
    if (rst_n && err) begin
      if (errQ.size() == 0) begin
        checkOutput("unexpected_err", {31'd0, err}, 32'd0);
      end else begin
        checkOutput("err_code", {30'd0, err_code}, {30'd0, errQ.pop_front()});
      end
    end
  end

  initial begin
    idleCycles(3);
    rst_n = 1'b1;
    checkResetValues("reset");

    // Good frame, exact drain length, then an immediate new header.
    pay = '{8'h01, 8'h02, 8'h03};
    sendGood(8'h10);
    idleCycles(2);
    checkOutput("drain_mid_valid", {31'd0, out_valid}, 32'd1);
    idleCycles(1);
    checkOutput("drain_end_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drain_end_queue", expQ.size(), 0);

    // Bad checksum starting in the first IDLE cycle after the drain.
    errQ.push_back(2'b10);
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h20);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'h00);
    idleCycles(1);
    checkOutput("sum_err_seen", errQ.size(), 0);
    pay = '{8'hDE, 8'hAD};
    sendGood(8'h21);
    waitDrain();
    checkOutput("err_code_held", {30'd0, err_code}, 32'd2);

    // Bad lengths, junk ignored in IDLE, then length boundaries 1 and 16.
    errQ.push_back(2'b01);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    idleCycles(1);
    errQ.push_back(2'b01);
    applyStimulus(8'hA5);
    applyStimulus(8'h11);
    idleCycles(1);
    checkOutput("len_err_seen", errQ.size(), 0);
    applyStimulus(8'h03);
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    idleCycles(2);
    pay = '{8'h7F};
    sendGood(8'h02);
    waitDrain();
    pay.delete();
    for (int i = 0; i < 16; i++) pay.push_back(8'($urandom_range(0, 255)));
    sendGood(8'h5A);
    waitDrain();

    // Byte exactly at the timeout terminal count restarts the counter.
    pay = '{8'h44, 8'h55};
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h30);
    idleCycles(19);
    applyStimulus(8'h44);
    idleCycles(19);
    applyStimulus(8'h55);
    pushFrame(8'h30);
    applyStimulus(frameSum(8'h30));
    waitDrain();

    // Genuine timeout after TIMEOUT_CYC silent cycles.
    errQ.push_back(2'b11);
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h30);
    idleCycles(20);
    checkOutput("tmo_err", {31'd0, err}, 32'd1);
    checkOutput("tmo_code", {30'd0, err_code}, 32'd3);
    idleCycles(1);
    checkOutput("tmo_err_seen", errQ.size(), 0);

    // Backpressure with bytes arriving during the drain.
    toggleMode = 1'b1;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    sendGood(8'h50);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    waitDrain();
    toggleMode = 1'b0;
    idleCycles(2);
    checkOutput("drop_cnt", {24'd0, drop_cnt}, 32'd3);

    // Reset in the middle of the payload.
    applyStimulus(8'hA5);
    applyStimulus(8'h04);
    applyStimulus(8'h40);
    applyStimulus(8'h01);
    rst_n = 1'b0;
    idleCycles(1);
    rst_n = 1'b1;
    checkResetValues("mid_reset");
    pay = '{8'h09, 8'h08, 8'h07, 8'h06};
    sendGood(8'h41);
    waitDrain();

    idleCycles(3);
    checkOutput("final_exp_queue", expQ.size(), 0);
    checkOutput("final_err_queue", errQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
